// File: rtl/read_arbiter_xbar_pkg.sv
// rtl/read_arbiter_xbar_pkg.sv - shared types and width helper for the read arbiter crossbar
package read_arbiter_xbar_pkg;

    typedef enum logic {
        SLV_IDLE = 1'b0,
        SLV_BUSY = 1'b1
    } slv_state_e;

    // Index width for n choices, never narrower than one bit
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/read_arbiter_xbar_rr_arbiter.sv
// rtl/read_arbiter_xbar_rr_arbiter.sv - round-robin pick of one requester starting at a pointer
module rr_arbiter
    import read_arbiter_xbar_pkg::*;
#(
    parameter int M      = 4,
    parameter int MSEL_W = width_of(M)
) (
    input  logic [M-1:0]      req,
    input  logic [MSEL_W-1:0] ptr,
    output logic [M-1:0]      gnt
);

    logic              found;
    logic [MSEL_W-1:0] idx;

    // Walk upward from the pointer, wrapping, and grant the first requester seen
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < M; k++) begin
            idx = MSEL_W'((int'(ptr) + k) % M);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_arbiter_xbar.sv
// rtl/read_arbiter_xbar.sv - M-master to S-slave read-address arbiter with outstanding limits
module read_arbiter_xbar
    import read_arbiter_xbar_pkg::*;
#(
    parameter int M                     = 4,
    parameter int S                     = 4,
    parameter int NUM_OUTSTANDING_TRANS = 4,
    parameter int ADDR_WIDTH            = 32,
    localparam int SEL_W  = width_of(S),
    localparam int MSEL_W = width_of(M),
    localparam int ID_W   = width_of(NUM_OUTSTANDING_TRANS),
    localparam int CNT_W  = $clog2(NUM_OUTSTANDING_TRANS + 1),
    localparam int XID_W  = MSEL_W + ID_W
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [M-1:0]            AR_request_f,
    input  logic [M*ADDR_WIDTH-1:0] AR_addr_f,
    input  logic [M*ID_W-1:0]       AR_id_f,
    input  logic [S-1:0]            AR_ready_s,
    input  logic [M-1:0]            R_last_f,
    output logic [M-1:0]            AR_grant_f,
    output logic [M*SEL_W-1:0]      AR_sel_f,
    output logic [M-1:0]            AR_decerr_f,
    output logic [S-1:0]            AR_valid_s,
    output logic [S*MSEL_W-1:0]     AR_mst_s,
    output logic [S*XID_W-1:0]      AR_id_s
);

    logic              arm;
    logic [SEL_W-1:0]  dec [M];
    logic [M-1:0]      decerr;
    logic [M-1:0]      granted;
    logic [M-1:0]      accept_m;
    logic [CNT_W-1:0]  cnt [M];

    slv_state_e        state   [S];
    slv_state_e        state_n [S];
    logic [MSEL_W-1:0] owner   [S];
    logic [MSEL_W-1:0] owner_n [S];
    logic [MSEL_W-1:0] ptr     [S];
    logic [MSEL_W-1:0] ptr_n   [S];
    logic [ID_W-1:0]   id_q    [S];
    logic [ID_W-1:0]   id_n    [S];
    logic [M-1:0]      elig    [S];
    logic [M-1:0]      win     [S];
    logic [MSEL_W-1:0] win_idx [S];
    logic [S-1:0]      accept;

    // Only the top address bits select a slave; the rest pass through untouched
    logic addr_unused;
    assign addr_unused = ^AR_addr_f;

    // Decode each master's target slave and flag targets beyond the last slave
    always_comb begin
        for (int i = 0; i < M; i++) begin
            dec[i]    = AR_addr_f[i*ADDR_WIDTH + ADDR_WIDTH - 1 -: SEL_W];
            decerr[i] = AR_request_f[i] && (int'(dec[i]) >= S);
        end
    end

    assign AR_decerr_f = decerr;

    // Masters currently owning some slave; a master may hold at most one grant
    always_comb begin
        granted = '0;
        for (int s = 0; s < S; s++) begin
            if (state[s] == SLV_BUSY) begin
                granted[owner[s]] = 1'b1;
            end
        end
    end

    // Per-slave eligibility: requesting this slave, under its limit, not already granted
    always_comb begin
        for (int s = 0; s < S; s++) begin
            for (int i = 0; i < M; i++) begin
                elig[s][i] = arm && AR_request_f[i] && !decerr[i]
                           && (dec[i] == SEL_W'(s))
                           && (cnt[i] < CNT_W'(NUM_OUTSTANDING_TRANS))
                           && !granted[i];
            end
        end
    end

    for (genvar g = 0; g < S; g++) begin : g_arb
        rr_arbiter #(
            .M      (M),
            .MSEL_W (MSEL_W)
        ) u_arb (
            .req (elig[g]),
            .ptr (ptr[g]),
            .gnt (win[g])
        );
    end

    // Convert each one-hot winner into a master index
    always_comb begin
        for (int s = 0; s < S; s++) begin
            win_idx[s] = '0;
            for (int i = 0; i < M; i++) begin
                if (win[s][i]) begin
                    win_idx[s] = MSEL_W'(i);
                end
            end
        end
    end

    // Slave FSM next state: grant from IDLE, accept or abort from BUSY
    always_comb begin
        accept = '0;
        for (int s = 0; s < S; s++) begin
            state_n[s] = state[s];
            owner_n[s] = owner[s];
            ptr_n[s]   = ptr[s];
            id_n[s]    = id_q[s];
            case (state[s])
                SLV_IDLE: begin
                    if (|elig[s]) begin
                        state_n[s] = SLV_BUSY;
                        owner_n[s] = win_idx[s];
                        id_n[s]    = AR_id_f[win_idx[s]*ID_W +: ID_W];
                    end
                end
                SLV_BUSY: begin
                    if (AR_ready_s[s]) begin
                        accept[s]  = 1'b1;
                        state_n[s] = SLV_IDLE;
                        ptr_n[s]   = MSEL_W'((int'(owner[s]) + 1) % M);
                    end else if (!AR_request_f[owner[s]]) begin
                        state_n[s] = SLV_IDLE;
                    end
                end
                default: state_n[s] = SLV_IDLE;
            endcase
        end
    end

    // Slave FSM registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int s = 0; s < S; s++) begin
                state[s] <= SLV_IDLE;
                owner[s] <= '0;
                ptr[s]   <= '0;
                id_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < S; s++) begin
                state[s] <= state_n[s];
                owner[s] <= owner_n[s];
                ptr[s]   <= ptr_n[s];
                id_q[s]  <= id_n[s];
            end
        end
    end

    // Route each slave accept back to the master that owned it
    always_comb begin
        accept_m = '0;
        for (int s = 0; s < S; s++) begin
            if (accept[s]) begin
                accept_m[owner[s]] = 1'b1;
            end
        end
    end

    // Outstanding counts: +1 on accept, -1 on last beat, both together cancel
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < M; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                if (accept_m[i] && !(R_last_f[i] && cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (!accept_m[i] && R_last_f[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Hold off arbitration for the first edge after reset release
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            arm <= 1'b0;
        end else begin
            arm <= 1'b1;
        end
    end

    // Drive grants and slave-side address channel from the BUSY slaves
    always_comb begin
        AR_grant_f = '0;
        AR_sel_f   = '0;
        AR_valid_s = '0;
        AR_mst_s   = '0;
        AR_id_s    = '0;
        for (int s = 0; s < S; s++) begin
            if (state[s] == SLV_BUSY) begin
                AR_grant_f[owner[s]]                 = 1'b1;
                AR_sel_f[owner[s]*SEL_W +: SEL_W]    = SEL_W'(s);
                AR_valid_s[s]                        = 1'b1;
                AR_mst_s[s*MSEL_W +: MSEL_W]         = owner[s];
                AR_id_s[s*XID_W +: XID_W]            = {owner[s], id_q[s]};
            end
        end
    end

endmodule
